// File: rtl/minterm_sweep_checker.sv
// Sweeps {a,b,c,d} through 0..15 into the 4-input minterm block and compares
// each settled response against the EXPECTED truth table.
module minterm_sweep_checker #(
    parameter logic [15:0] EXPECTED      = 16'h6EEE,
    parameter int          SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        dut_result,
    output logic [3:0]  dut_vec,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err_idx,
    output logic        first_err_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       record;
    logic       mismatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        record     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = SETTLE;
                    accept     = 1'b1;
                end
            end
            SETTLE: begin
                if (abort)                          state_next = IDLE;
                else if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
            end
            SAMPLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    record     = 1'b1;
                    state_next = (dut_vec == 4'd15) ? DONE : SETTLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mismatch = (dut_result != EXPECTED[dut_vec]);
    assign busy     = (state == SETTLE) || (state == SAMPLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dut_vec         <= '0;
            settle_cnt      <= '0;
            pass            <= 1'b0;
            truth_table     <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else if (accept) begin
            dut_vec         <= '0;
            settle_cnt      <= '0;
            pass            <= 1'b0;
            truth_table     <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else if (state == SETTLE && !abort) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else if (record) begin
            truth_table[dut_vec] <= dut_result;
            if (mismatch) begin
                err_count <= err_count + 5'd1;
                if (!first_err_valid) begin
                    first_err_idx   <= dut_vec;
                    first_err_valid <= 1'b1;
                end
            end
            // pass is settled here so it is already valid alongside the done pulse
            if (dut_vec == 4'd15) begin
                pass <= (err_count == 5'd0) && !mismatch;
            end else begin
                dut_vec    <= dut_vec + 4'd1;
                settle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: a timeline-based model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_minterm_sweep_checker;

    localparam int SETTLE = 1;
    localparam int PER    = SETTLE + 1;
    localparam int LAST   = 16 * PER;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        dut_result;
    logic [3:0]  dut_vec;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] truth_table;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        first_err_valid;

    int mode = 0;
    int vectors = 0;
    int miscompares = 0;
    bit armed = 0;

    always #5 clk = ~clk;

    minterm_sweep_checker #(.EXPECTED(16'h6EEE), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .dut_result(dut_result), .dut_vec(dut_vec), .busy(busy), .done(done),
        .pass(pass), .truth_table(truth_table), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
    );

    // Golden function: (c|d) & ~(a&b&c&d)
    function automatic logic golden(input logic [3:0] v);
        return (v[1] | v[0]) & ~(&v);
    endfunction

    // Function block under test: 0 = correct, 1 = stuck-at-0, 2 = plain c|d
    function automatic logic block_fn(input int md, input logic [3:0] v);
        case (md)
            0:       return golden(v);
            1:       return 1'b0;
            default: return v[1] | v[0];
        endcase
    endfunction

    assign dut_result = block_fn(mode, dut_vec);

    // Model: time since the accepted start decides everything
    bit          run;
    int          k;
    logic [15:0] m_tt;
    int          m_err;
    logic [3:0]  m_fidx;
    logic [3:0]  m_vec;
    bit          m_fv;
    bit          m_pass;
    int          s_idx;
    logic        s_r;
    logic        s_e;

    always_comb begin
        s_idx = k / PER - 1;
        s_r   = block_fn(mode, 4'(s_idx));
        s_e   = golden(4'(s_idx));
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 0; k <= 0; m_tt <= '0; m_err <= 0; m_fidx <= '0;
            m_vec <= '0; m_fv <= 0; m_pass <= 0;
        end else if (!run) begin
            if (start && !abort) begin
                run <= 1; k <= 1; m_tt <= '0; m_err <= 0; m_fidx <= '0;
                m_vec <= '0; m_fv <= 0; m_pass <= 0;
            end
        end else if (k == LAST + 1) begin
            run <= 0;
        end else if (abort) begin
            run <= 0;
        end else begin
            k <= k + 1;
            if (k % PER == 0) begin
                m_tt[s_idx] <= s_r;
                if (s_r != s_e) begin
                    m_err <= m_err + 1;
                    if (!m_fv) begin
                        m_fidx <= 4'(s_idx);
                        m_fv   <= 1;
                    end
                end
                if (s_idx == 15) m_pass <= (m_err == 0) && (s_r == s_e);
                else             m_vec  <= 4'(s_idx + 1);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("busy", 16'(busy), 16'(run && k <= LAST));
            check("done", 16'(done), 16'(run && k == LAST + 1));
            check("dut_vec", 16'(dut_vec), 16'(m_vec));
            check("pass", 16'(pass), 16'(m_pass));
            check("truth_table", truth_table, m_tt);
            check("err_count", 16'(err_count), 16'(m_err));
            check("first_err_idx", 16'(first_err_idx), 16'(m_fidx));
            check("first_err_valid", 16'(first_err_valid), 16'(m_fv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(output int lat);
        start = 1;
        tick();
        start = 0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_vec(input logic [3:0] v);
        int n = 0;
        while (dut_vec !== v && n < 100) begin
            tick();
            n++;
        end
        check("reach_vec", 16'(dut_vec), 16'(v));
    endtask

    int lat;
    int dones;

    initial begin
        reset_n = 0; start = 0; abort = 0;
        repeat (3) tick();
        armed = 1;
        tick();
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_tt", truth_table, 16'h0);
        reset_n = 1;
        tick();

        // correct block
        mode = 0;
        sweep(lat);
        check("lat_good", 16'(lat), 16'd33);
        check("tt_good", truth_table, 16'h6EEE);
        check("err_good", 16'(err_count), 16'd0);
        check("fv_good", 16'(first_err_valid), 16'd0);
        check("pass_good", 16'(pass), 16'd1);
        tick();
        check("vec_hold", 16'(dut_vec), 16'd15);
        check("idle_busy", 16'(busy), 16'd0);

        // stuck-at-0 block
        mode = 1;
        sweep(lat);
        check("lat_s0", 16'(lat), 16'd33);
        check("tt_s0", truth_table, 16'h0000);
        check("err_s0", 16'(err_count), 16'd11);
        check("fidx_s0", 16'(first_err_idx), 16'd1);
        check("fv_s0", 16'(first_err_valid), 16'd1);
        check("pass_s0", 16'(pass), 16'd0);
        tick();

        // plain c|d block
        mode = 2;
        sweep(lat);
        check("tt_or", truth_table, 16'hEEEE);
        check("err_or", 16'(err_count), 16'd1);
        check("fidx_or", 16'(first_err_idx), 16'd15);
        check("pass_or", 16'(pass), 16'd0);
        tick();
        mode = 0;

        // abort at vector 7
        start = 1; tick(); start = 0;
        wait_vec(4'd7);
        abort = 1; tick(); abort = 0;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_pass", 16'(pass), 16'd0);
        check("abort_tt", truth_table, 16'h006E);
        dones = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("abort_nodone", 16'(dones), 16'd0);

        // reset mid-sweep at vector 9
        start = 1; tick(); start = 0;
        wait_vec(4'd9);
        reset_n = 0;
        #1;
        check("mrst_vec", 16'(dut_vec), 16'd0);
        check("mrst_busy", 16'(busy), 16'd0);
        check("mrst_tt", truth_table, 16'h0);
        check("mrst_err", 16'(err_count), 16'd0);
        check("mrst_fv", 16'(first_err_valid), 16'd0);
        tick(); tick();
        reset_n = 1;
        tick();
        sweep(lat);
        check("mrst_lat", 16'(lat), 16'd33);
        check("mrst_tt2", truth_table, 16'h6EEE);
        check("mrst_pass", 16'(pass), 16'd1);
        tick();

        // start re-pulsed while busy, then start+abort in idle
        start = 1; tick(); start = 0;
        lat = 1;
        while (dut_vec !== 4'd4 && lat < 100) begin tick(); lat++; end
        start = 1; tick(); lat++; start = 0;
        while (done !== 1'b1 && lat < 200) begin tick(); lat++; end
        check("restart_lat", 16'(lat), 16'd33);
        check("restart_tt", truth_table, 16'h6EEE);
        check("restart_pass", 16'(pass), 16'd1);
        tick();
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        check("sa_busy", 16'(busy), 16'd0);
        tick();
        check("sa_busy2", 16'(busy), 16'd0);
        check("sa_vec", 16'(dut_vec), 16'd15);
        check("sa_pass", 16'(pass), 16'd1);

        armed = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/minterm_sweep_checker.md
Name: minterm_sweep_checker

Overview:
Sequential stimulus and response stage placed directly upstream of the 4-input minterm function block; it also consumes that block's output. On a start request it walks the input vector {a,b,c,d} through 0..15 and drives the function block. For each vector it samples the block's result, builds the observed 16-entry truth table, and compares it against an expected table. It reports pass/fail, the mismatch count and the first failing index.

Parameters:
EXPECTED, 16'h6EEE, expected truth table; bit i = required result for {a,b,c,d}=i. The default encodes (c|d)&~(a&b&c&d).
SETTLE_CYCLES, 1, cycles a vector is held before sampling. Legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
abort  input  1  cancels a running sweep
dut_result  input  1  result output of the minterm function block
dut_vec  output  4  stimulus to the function block; [3]=a, [2]=b, [1]=c, [0]=d
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes; never raised on abort
pass  output  1  high when the last completed sweep had zero mismatches
truth_table  output  16  observed results; bit i captured for vector i
err_count  output  5  number of mismatching vectors, 0..16
first_err_idx  output  4  index of the lowest mismatching vector
first_err_valid  output  1  high when first_err_idx is meaningful

Behaviour:
- Reset is asynchronous and active-low: one clock, clk; reset is reset_n.
- While reset_n=0, all outputs are 0: state=IDLE, dut_vec=0, busy=0, done=0, pass=0, truth_table=0, err_count=0, first_err_idx=0, first_err_valid=0, settle counter=0.
- Reset asserted mid-sweep aborts immediately. No done pulse is produced.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE with start=1 and abort=0:
  - Clear truth_table, err_count, first_err_*, and pass.
  - Set dut_vec=0 and settle counter=0.
  - Go to SETTLE. busy=1 from the next cycle.
- IDLE with start=1 and abort=1: stay in IDLE; abort wins.
- SETTLE: hold dut_vec and increment the counter. When the counter reaches SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE, with i = dut_vec:
  - Register dut_result into truth_table[i].
  - If dut_result != EXPECTED[i]: err_count += 1. If first_err_valid=0, set first_err_idx=i and first_err_valid=1.
  - If i=15, go to DONE. Otherwise dut_vec = i+1, counter=0, go to SETTLE.
- Counting within a vector uses the settle counter. The expected response is a combinational comparison in the same SAMPLE cycle.
- DONE (one cycle):
  - done=1, busy=0.
  - pass=1 iff err_count==0, using the value including the final sample.
  - Return to IDLE. dut_vec stays at 15 until the next start.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles.
  - The done pulse appears 16*(SETTLE_CYCLES+1)+1 cycles after the start edge. With default SETTLE_CYCLES=1, this is 33.
- busy is high in SETTLE and SAMPLE only.
- start while busy is ignored and has no side effects.
- abort in SETTLE or SAMPLE: next state is IDLE and busy=0.
  - No done pulse. pass=0.
  - The partial truth_table, err_count and first_err_* are held. The aborted SAMPLE cycle is not recorded.
- err_count is 5 bits wide, so 16 mismatches fit. No saturation logic is needed.
- Results hold stable in IDLE until the next accepted start.

Test Plan:
- Correct DUT model, default parameters, start pulse -> done exactly 33 cycles later; pass=1, truth_table=16'h6EEE, err_count=0, first_err_valid=0.
- dut_result stuck at 0 -> truth_table=16'h0000, err_count=11, first_err_idx=1, first_err_valid=1, pass=0.
- DUT returns 1 at vector 15 (plain c|d) -> truth_table=16'hEEEE, err_count=1, first_err_idx=15, pass=0.
- abort asserted while dut_vec=7 -> busy=0 next cycle, no done pulse, pass=0, truth_table bits 7..15 remain 0.
- reset_n pulled low mid-sweep (dut_vec=9), released, then new start -> all outputs 0 during reset; a clean full sweep then passes with 16'h6EEE.
- start re-pulsed at dut_vec=4, and start+abort together in IDLE -> the running sweep is unaffected and completes normally; the simultaneous pair leaves the block in IDLE with busy=0.
